// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and constants for the memory responder:
//   state_t             responder FSM states (IDLE, IFETCH, DACCESS)
//   DEF_ADDR_W          default address width
//   DEF_DATA_W          default data width
//   DEF_TIMEOUT_CYCLES  default access timeout (used only with MEM_TIMEOUT_EN)
//   BAD_DATA            load value returned by an access aborted on timeout
// -----------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Bundles the core-side request/response signals and the RAM-side port of
// the memory responder.
//   modport slave  : the responder's view (requests and RAM results in,
//                    loads, ready pulses, RAM strobes and bus_err out)
//   modport master : the environment's view (core + RAM), directions reversed
// -----------------------------------------------------------------------------
interface mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // core instruction side
    logic              iren;
    logic [ADDR_W-1:0] imemaddr;
    logic [DATA_W-1:0] imemload;
    logic              i_ready;

    // core data side
    logic              dmmRen;
    logic              dmmWen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic [DATA_W-1:0] dmmload;
    logic              d_ready;

    // RAM side
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              ramRen;
    logic              ramWen;
    logic [DATA_W-1:0] ramload;
    logic              ram_ack;

    // status
    logic              bus_err;

    modport slave (
        input  iren, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ramload, ram_ack,
        output imemload, i_ready, dmmload, d_ready, ramaddr, ramstore, ramRen, ramWen,
               bus_err
    );

    modport master (
        output iren, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ramload, ram_ack,
        input  imemload, i_ready, dmmload, d_ready, ramaddr, ramstore, ramRen, ramWen,
               bus_err
    );

endinterface

// File: rtl/mem_responder_access_timer.sv
// -----------------------------------------------------------------------------
// access_timer
// Counts access-state cycles that pass without a RAM acknowledge and flags
// expiry on the cycle in which the TIMEOUT_CYCLES-th such cycle ends.
// Instantiated by mem_responder only when MEM_TIMEOUT_EN is defined.
// Ports:
//   clk       clock, rising edge
//   nRST      asynchronous active-low reset
//   start_i   access entry edge: clears the count
//   active_i  responder is in an access state this cycle
//   ack_i     RAM acknowledge this cycle
//   expire_o  access has run its full budget; abort on this edge
// -----------------------------------------------------------------------------
module access_timer
    import mem_resp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic nRST,
    input  logic start_i,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the number of ack-less cycles already completed, so the
    // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign expire_o = active_i && !ack_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (active_i && !ack_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder: arbitrates instruction fetches and data accesses
// onto one shared RAM port, holds the RAM strobe until ram_ack, returns the
// read data and pulses i_ready / d_ready for one cycle per access.
// Data requests win over fetches; a simultaneous read+write request is a write.
// Ports:
//   clk   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   mem_responder_if.slave (core request/response + RAM port + bus_err)
// Configuration:
//   MEM_TIMEOUT_EN  when defined, an access that sees no ram_ack for
//                   TIMEOUT_CYCLES cycles is aborted, returns BAD_DATA and sets
//                   the sticky bus_err flag. Undefined: waits forever, bus_err=0.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           nRST,
    mem_responder_if.slave bus
);

    state_t            state_q;
    state_t            state_d;

    logic              is_write_q;
    logic [ADDR_W-1:0] ramaddr_q;
    logic [DATA_W-1:0] ramstore_q;
    logic [DATA_W-1:0] imemload_q;
    logic [DATA_W-1:0] dmmload_q;
    logic              i_ready_q;
    logic              d_ready_q;

    logic              ram_ren;
    logic              ram_wen;
    logic              data_req;
    logic              ready_guard;
    logic              entering;
    logic              in_access;
    logic              expired;
    logic              finish;
    logic [DATA_W-1:0] result_data;

    assign data_req    = bus.dmmRen | bus.dmmWen;
    // While a ready pulse is out the core has not yet seen it, so its request
    // lines still describe the access just completed and must be ignored.
    assign ready_guard = i_ready_q | d_ready_q;
    assign in_access   = (state_q != IDLE);
    assign entering    = (state_q == IDLE) && (state_d != IDLE);
    assign finish      = in_access && (bus.ram_ack || expired);
    // An ack arriving on the abort edge still delivers real data.
    assign result_data = bus.ram_ack ? bus.ramload : DATA_W'(BAD_DATA);

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q;

    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_access_timer (
        .clk      (clk),
        .nRST     (nRST),
        .start_i  (entering),
        .active_i (in_access),
        .ack_i    (bus.ram_ack),
        .expire_o (expired)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bus_err_q <= 1'b0;
        end else if (expired) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign expired     = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!ready_guard) begin
                    if (data_req) begin
                        state_d = DACCESS;
                    end else if (bus.iren) begin
                        state_d = IFETCH;
                    end
                end
            end
            IFETCH, DACCESS: begin
                if (bus.ram_ack || expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Strobes follow the state register, so they drop on the completing edge
    // and immediately on reset.
    always_comb begin
        ram_ren = 1'b0;
        ram_wen = 1'b0;
        case (state_q)
            IFETCH:  ram_ren = 1'b1;
            DACCESS: begin
                ram_ren = !is_write_q;
                ram_wen = is_write_q;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            is_write_q <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            imemload_q <= '0;
            dmmload_q  <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;

            if (entering) begin
                if (state_d == DACCESS) begin
                    ramaddr_q  <= bus.dmmaddr;
                    ramstore_q <= bus.dmmstore;
                    is_write_q <= bus.dmmWen;
                end else begin
                    ramaddr_q  <= bus.imemaddr;
                    is_write_q <= 1'b0;
                end
            end

            if (finish) begin
                if (state_q == IFETCH) begin
                    imemload_q <= result_data;
                    i_ready_q  <= 1'b1;
                end else begin
                    // Writes leave the previous load value in place.
                    if (!is_write_q) begin
                        dmmload_q <= result_data;
                    end
                    d_ready_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ramaddr  = ramaddr_q;
    assign bus.ramstore = ramstore_q;
    assign bus.ramRen   = ram_ren;
    assign bus.ramWen   = ram_wen;
    assign bus.imemload = imemload_q;
    assign bus.dmmload  = dmmload_q;
    assign bus.i_ready  = i_ready_q;
    assign bus.d_ready  = d_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. A RAM model answers strobes after a
// programmable delay; a core-level reference model (address -> word map plus
// the last expected fetch/load values) predicts every result.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_responder #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------- RAM model
    logic [31:0] ram_mem [logic [31:0]];
    int          ack_delay = 0;
    bit          ram_en    = 1'b1;
    int          wait_cnt  = 0;
    bit          prev_strobe = 1'b0;
    int          strobe_cycles = 0;
    int          unstable = 0;
    int          acc_cnt = 0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    logic [31:0] first_addr, first_store, last_addr, last_store;
    logic        first_wr, last_wr;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always @(negedge clk) begin
        bus.ram_ack = 1'b0;
        bus.ramload = $urandom;
        if (bus.i_ready) i_cnt++;
        if (bus.d_ready) d_cnt++;
        if (nRST && (bus.ramRen || bus.ramWen)) begin
            strobe_cycles++;
            if (!prev_strobe) begin
                first_addr  = bus.ramaddr;
                first_store = bus.ramstore;
                first_wr    = bus.ramWen;
            end else if (bus.ramaddr !== first_addr || bus.ramstore !== first_store ||
                         bus.ramWen !== first_wr) begin
                unstable++;
            end
            if (bus.ramRen && bus.ramWen) unstable++;
            if (ram_en && wait_cnt == ack_delay) begin
                bus.ram_ack = 1'b1;
                acc_cnt++;
                last_addr  = bus.ramaddr;
                last_store = bus.ramstore;
                last_wr    = bus.ramWen;
                if (bus.ramWen) ram_mem[bus.ramaddr] = bus.ramstore;
                else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr]
                                                               : init_word(bus.ramaddr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            prev_strobe = 1'b1;
        end else begin
            wait_cnt    = 0;
            prev_strobe = 1'b0;
        end
    end

    // ---------------------------------------------------- reference model
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] exp_imemload = '0;
    logic [31:0] exp_dmmload  = '0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ram_mem[a]   = d;
        model_mem[a] = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drop_requests();
        bus.iren   = 1'b0;
        bus.dmmRen = 1'b0;
        bus.dmmWen = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_imemload"}, bus.imemload, 32'h0);
        check({tag, "_dmmload"},  bus.dmmload,  32'h0);
        check({tag, "_ramaddr"},  bus.ramaddr,  32'h0);
        check({tag, "_ramstore"}, bus.ramstore, 32'h0);
        check({tag, "_strobes"},  {30'h0, bus.ramRen, bus.ramWen}, 32'h0);
        check({tag, "_ready"},    {30'h0, bus.i_ready, bus.d_ready}, 32'h0);
        check({tag, "_bus_err"},  {31'h0, bus.bus_err}, 32'h0);
    endtask

    // kind: 0 fetch, 1 data read, 2 data write
    task automatic core_access(input int kind, input logic [31:0] addr, input logic [31:0] data,
                               input int delay, input bit hold_extra);
        int  k;
        bit  seen;
        int  acc0, i0, d0, sc0, un0;
        @(negedge clk);
        ack_delay = delay;
        acc0 = acc_cnt; i0 = i_cnt; d0 = d_cnt; sc0 = strobe_cycles; un0 = unstable;
        case (kind)
            0:       begin bus.iren = 1'b1; bus.imemaddr = addr; end
            1:       begin bus.dmmRen = 1'b1; bus.dmmaddr = addr; bus.dmmstore = $urandom; end
            default: begin bus.dmmWen = 1'b1; bus.dmmaddr = addr; bus.dmmstore = data; end
        endcase
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if ((kind == 0) ? bus.i_ready : bus.d_ready) seen = 1'b1;
        end
        if (!seen) begin
            check("ready_timeout", 32'h0, 32'h1);
            drop_requests();
            return;
        end
        check("latency", k, delay + 2);
        if (kind == 2) model_mem[addr] = data;
        else if (kind == 1) exp_dmmload = model_read(addr);
        else exp_imemload = model_read(addr);
        check("imemload", bus.imemload, exp_imemload);
        check("dmmload", bus.dmmload, exp_dmmload);
        if (!hold_extra) drop_requests();
        @(negedge clk);
        check("ready_one_cycle", {30'h0, bus.i_ready, bus.d_ready}, 32'h0);
        drop_requests();
        repeat (delay + 4) @(negedge clk);
        #1;
        check("ram_accesses", acc_cnt - acc0, 1);
        check("i_ready_pulses", i_cnt - i0, (kind == 0) ? 1 : 0);
        check("d_ready_pulses", d_cnt - d0, (kind == 0) ? 0 : 1);
        check("strobe_cycles", strobe_cycles - sc0, delay + 1);
        check("strobe_stable", unstable - un0, 0);
        check("ram_addr", last_addr, addr);
        check("ram_is_write", {31'h0, last_wr}, (kind == 2) ? 32'h1 : 32'h0);
        if (kind == 2) check("ram_store", last_store, data);
        $display("txn kind=%0d addr=%h data=%h delay=%0d hold=%0d imemload=%h dmmload=%h",
                 kind, addr, data, delay, hold_extra, bus.imemload, bus.dmmload);
    endtask

    initial begin
        int k;
        bit seen;
        int acc0, d0, sc0;

        nRST = 1'b0;
        drop_requests();
        bus.imemaddr = '0;
        bus.dmmaddr  = '0;
        bus.dmmstore = '0;
        preload(32'h0000_0040, 32'h0050_0093);
        preload(32'h0000_0080, 32'h0000_0013);
        preload(32'h0000_0100, 32'hA5A5_0100);
        preload(32'h0000_0210, 32'h0000_1234);

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        nRST = 1'b1;

        // fetch: ramRen held 3 cycles, ack on the third
        core_access(0, 32'h0000_0040, 32'h0, 2, 1'b0);

        // priority: data and fetch requested together
        @(negedge clk);
        ack_delay = 1;
        acc0 = acc_cnt;
        bus.iren = 1'b1; bus.imemaddr = 32'h0000_0080;
        bus.dmmRen = 1'b1; bus.dmmaddr = 32'h0000_0100;
        seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (bus.d_ready || bus.i_ready) seen = 1'b1;
        end
        check("prio_data_first", {30'h0, bus.i_ready, bus.d_ready}, 32'h1);
        check("prio_addr", last_addr, 32'h0000_0100);
        exp_dmmload = model_read(32'h0000_0100);
        check("prio_dmmload", bus.dmmload, exp_dmmload);
        check("prio_imemload_kept", bus.imemload, exp_imemload);
        bus.dmmRen = 1'b0;
        seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (bus.i_ready) seen = 1'b1;
        end
        check("prio_fetch_gap", k, 4);
        exp_imemload = model_read(32'h0000_0080);
        check("prio_imemload", bus.imemload, exp_imemload);
        bus.iren = 1'b0;
        @(negedge clk); #1;
        check("prio_accesses", acc_cnt - acc0, 2);
        $display("txn priority dmm=%h then fetch=%h imemload=%h", bus.dmmload, 32'h80, bus.imemload);

        // write keeps dmmload, then re-issue guard on a readback
        core_access(1, 32'h0000_0210, 32'h0, 1, 1'b0);
        core_access(2, 32'h0000_0200, 32'hCAFE_F00D, 0, 1'b0);
        check("write_keeps_dmmload", bus.dmmload, 32'h0000_1234);
        core_access(1, 32'h0000_0200, 32'h0, 3, 1'b1);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        ram_en = 1'b0;
        acc0 = acc_cnt; sc0 = strobe_cycles;
        bus.iren = 1'b1; bus.imemaddr = 32'h0000_0400;
        seen = 1'b0; k = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (bus.i_ready) seen = 1'b1;
        end
        check("timeout_latency", k, 9);
        exp_imemload = BAD_DATA;
        check("timeout_imemload", bus.imemload, exp_imemload);
        check("timeout_bus_err", {31'h0, bus.bus_err}, 32'h1);
        bus.iren = 1'b0;
        @(negedge clk); #1;
        ram_en = 1'b1;
        check("timeout_strobe_cycles", strobe_cycles - sc0, 8);
        check("timeout_no_ack", acc_cnt - acc0, 0);
        $display("txn timeout fetch addr=%h imemload=%h bus_err=%0d", 32'h400, bus.imemload, bus.bus_err);
`endif

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            core_access($urandom_range(0, 2), 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4,
                        $urandom, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
        end

`ifdef MEM_TIMEOUT_EN
        check("bus_err_sticky", {31'h0, bus.bus_err}, 32'h1);
`else
        check("bus_err_tied", {31'h0, bus.bus_err}, 32'h0);
`endif

        // reset in the middle of a write
        @(negedge clk);
        ack_delay = 10;
        acc0 = acc_cnt; d0 = d_cnt;
        bus.dmmWen = 1'b1; bus.dmmaddr = 32'h0000_0300; bus.dmmstore = 32'h1111_2222;
        repeat (2) @(negedge clk);
        check("pre_reset_ramWen", {31'h0, bus.ramWen}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("reset_drops_strobes", {30'h0, bus.ramRen, bus.ramWen}, 32'h0);
        drop_requests();
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("midreset");
        check("midreset_state", 32'(dut.state_q), 32'(IDLE));
        check("midreset_no_ready", d_cnt - d0, 0);
        check("midreset_no_access", acc_cnt - acc0, 0);
        $display("txn reset mid-write addr=%h", 32'h300);
        exp_imemload = '0;
        exp_dmmload  = '0;
        @(negedge clk);
        nRST = 1'b1;
        core_access(1, 32'h0000_0300, 32'h0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
